// File: rtl/cc_raster_collector.sv
// Reduces each frame of the CC geometry engine's coordinate stream to one summary
// record (counts, bounding box, sums, raster-order flag) offered on a valid/ready port.
module cc_raster_collector #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [1:0]              in_mode,
  input  logic signed [7:0]       xi,
  input  logic signed [7:0]       yi,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [1:0]              out_mode,
  output logic [CNT_W-1:0]        out_cnt,
  output logic [CNT_W-1:0]        out_rows,
  output logic signed [7:0]       out_xmin,
  output logic signed [7:0]       out_xmax,
  output logic signed [7:0]       out_ymin,
  output logic signed [7:0]       out_ymax,
  output logic signed [SUM_W-1:0] out_sumx,
  output logic signed [SUM_W-1:0] out_sumy,
  output logic                    out_oerr,
  output logic                    out_drop
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                  state_reg, state_next;
  logic [1:0]              mode_reg, mode_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]        rows_reg, rows_next;
  logic signed [7:0]       xmin_reg, xmin_next;
  logic signed [7:0]       xmax_reg, xmax_next;
  logic signed [7:0]       ymin_reg, ymin_next;
  logic signed [7:0]       ymax_reg, ymax_next;
  logic signed [SUM_W-1:0] sumx_reg, sumx_next;
  logic signed [SUM_W-1:0] sumy_reg, sumy_next;
  logic                    oerr_reg, oerr_next;
  logic signed [7:0]       x_prev_reg, x_prev_next;
  logic signed [7:0]       y_prev_reg, y_prev_next;

  logic                    rec_valid_reg, rec_valid_next;
  logic [1:0]              rec_mode_reg;
  logic [CNT_W-1:0]        rec_cnt_reg;
  logic [CNT_W-1:0]        rec_rows_reg;
  logic signed [7:0]       rec_xmin_reg;
  logic signed [7:0]       rec_xmax_reg;
  logic signed [7:0]       rec_ymin_reg;
  logic signed [7:0]       rec_ymax_reg;
  logic signed [SUM_W-1:0] rec_sumx_reg;
  logic signed [SUM_W-1:0] rec_sumy_reg;
  logic                    rec_oerr_reg;
  logic                    drop_reg, drop_next;

  // Successor coordinates are compared at 9 bits so 127+1 never aliases to -128.
  logic [8:0]              x_succ, y_succ, xi_ext9, yi_ext9;
  logic                    row_step, col_step, order_ok;
  logic signed [SUM_W-1:0] xi_ext, yi_ext;
  logic                    commit, rec_load;

  assign x_succ   = {x_prev_reg[7], x_prev_reg} + 9'd1;
  assign y_succ   = {y_prev_reg[7], y_prev_reg} + 9'd1;
  assign xi_ext9  = {xi[7], xi};
  assign yi_ext9  = {yi[7], yi};
  assign row_step = (yi_ext9 == y_succ);
  assign col_step = (yi == y_prev_reg) && (xi_ext9 == x_succ);
  assign order_ok = row_step || col_step;

  assign xi_ext = {{(SUM_W-8){xi[7]}}, xi};
  assign yi_ext = {{(SUM_W-8){yi[7]}}, yi};

  assign commit   = (state_reg == ST_ACCUM) && !in_valid;
  assign rec_load = commit && !(rec_valid_reg && !out_ready);

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    cnt_next    = cnt_reg;
    rows_next   = rows_reg;
    xmin_next   = xmin_reg;
    xmax_next   = xmax_reg;
    ymin_next   = ymin_reg;
    ymax_next   = ymax_reg;
    sumx_next   = sumx_reg;
    sumy_next   = sumy_reg;
    oerr_next   = oerr_reg;
    x_prev_next = x_prev_reg;
    y_prev_next = y_prev_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next  = ST_ACCUM;
          mode_next   = in_mode;
          cnt_next    = CNT_ONE;
          rows_next   = CNT_ONE;
          xmin_next   = xi;
          xmax_next   = xi;
          ymin_next   = yi;
          ymax_next   = yi;
          sumx_next   = xi_ext;
          sumy_next   = yi_ext;
          oerr_next   = 1'b0;
          x_prev_next = xi;
          y_prev_next = yi;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_ONE;
          if (row_step && rows_reg != CNT_MAX) rows_next = rows_reg + CNT_ONE;
          if (xi < xmin_reg) xmin_next = xi;
          if (xi > xmax_reg) xmax_next = xi;
          if (yi < ymin_reg) ymin_next = yi;
          if (yi > ymax_reg) ymax_next = yi;
          sumx_next = sumx_reg + xi_ext;
          sumy_next = sumy_reg + yi_ext;
          // Only the trapezoid raster (mode 0) has a defined beat order.
          if (mode_reg == 2'd0 && !order_ok) oerr_next = 1'b1;
          x_prev_next = xi;
          y_prev_next = yi;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rec_valid_next = rec_valid_reg;
    drop_next      = drop_reg;
    if (rec_load) begin
      rec_valid_next = 1'b1;
    end else if (rec_valid_reg && out_ready) begin
      rec_valid_next = 1'b0;
    end
    if (commit && rec_valid_reg && !out_ready) drop_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= '0;
      cnt_reg    <= '0;
      rows_reg   <= '0;
      xmin_reg   <= '0;
      xmax_reg   <= '0;
      ymin_reg   <= '0;
      ymax_reg   <= '0;
      sumx_reg   <= '0;
      sumy_reg   <= '0;
      oerr_reg   <= 1'b0;
      x_prev_reg <= '0;
      y_prev_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      cnt_reg    <= cnt_next;
      rows_reg   <= rows_next;
      xmin_reg   <= xmin_next;
      xmax_reg   <= xmax_next;
      ymin_reg   <= ymin_next;
      ymax_reg   <= ymax_next;
      sumx_reg   <= sumx_next;
      sumy_reg   <= sumy_next;
      oerr_reg   <= oerr_next;
      x_prev_reg <= x_prev_next;
      y_prev_reg <= y_prev_next;
    end
  end

  // Record registers only change on an accepted commit; a stalled record is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid_reg <= 1'b0;
      rec_mode_reg  <= '0;
      rec_cnt_reg   <= '0;
      rec_rows_reg  <= '0;
      rec_xmin_reg  <= '0;
      rec_xmax_reg  <= '0;
      rec_ymin_reg  <= '0;
      rec_ymax_reg  <= '0;
      rec_sumx_reg  <= '0;
      rec_sumy_reg  <= '0;
      rec_oerr_reg  <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      rec_valid_reg <= rec_valid_next;
      drop_reg      <= drop_next;
      if (rec_load) begin
        rec_mode_reg <= mode_reg;
        rec_cnt_reg  <= cnt_reg;
        rec_rows_reg <= rows_reg;
        rec_xmin_reg <= xmin_reg;
        rec_xmax_reg <= xmax_reg;
        rec_ymin_reg <= ymin_reg;
        rec_ymax_reg <= ymax_reg;
        rec_sumx_reg <= sumx_reg;
        rec_sumy_reg <= sumy_reg;
        rec_oerr_reg <= oerr_reg;
      end
    end
  end

  assign out_valid = rec_valid_reg;
  assign out_mode  = rec_mode_reg;
  assign out_cnt   = rec_cnt_reg;
  assign out_rows  = rec_rows_reg;
  assign out_xmin  = rec_xmin_reg;
  assign out_xmax  = rec_xmax_reg;
  assign out_ymin  = rec_ymin_reg;
  assign out_ymax  = rec_ymax_reg;
  assign out_sumx  = rec_sumx_reg;
  assign out_sumy  = rec_sumy_reg;
  assign out_oerr  = rec_oerr_reg;
  assign out_drop  = drop_reg;

endmodule

// File: tb/tb_cc_raster_collector.sv
// Bench for cc_raster_collector: directed and random frames checked against a
// frame-level reference model of the summary record and the record handshake.
module tb_cc_raster_collector;

  localparam int CNT_W = 16;
  localparam int SUM_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n, in_valid, out_ready;
  logic [1:0]              in_mode;
  logic signed [7:0]       xi, yi;
  logic                    out_valid, out_oerr, out_drop;
  logic [1:0]              out_mode;
  logic [CNT_W-1:0]        out_cnt, out_rows;
  logic signed [7:0]       out_xmin, out_xmax, out_ymin, out_ymax;
  logic signed [SUM_W-1:0] out_sumx, out_sumy;

  cc_raster_collector #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode),
    .xi(xi), .yi(yi), .out_ready(out_ready), .out_valid(out_valid),
    .out_mode(out_mode), .out_cnt(out_cnt), .out_rows(out_rows),
    .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
    .out_sumx(out_sumx), .out_sumy(out_sumy), .out_oerr(out_oerr), .out_drop(out_drop)
  );

  typedef struct packed {
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rows;
    logic [7:0]       xmin, xmax, ymin, ymax;
    logic [SUM_W-1:0] sumx, sumy;
    logic             oerr;
  } rec_t;

  rec_t dut_rec;
  assign dut_rec = {out_mode, out_cnt, out_rows, out_xmin, out_xmax, out_ymin, out_ymax,
                    out_sumx, out_sumy, out_oerr};

  int   errors = 0;
  int   checks = 0;
  int   bx[$];
  int   by[$];
  logic exp_drop = 1'b0;

  // Reference: summarise the whole beat list of a frame using plain integer arithmetic.
  function automatic rec_t model_rec(input logic [1:0] mode);
    rec_t r;
    int n, sx, sy, xmn, xmx, ymn, ymx, rows;
    logic oerr;
    logic legal;
    n = bx.size();
    sx = 0; sy = 0; rows = 1; oerr = 1'b0;
    xmn = bx[0]; xmx = bx[0]; ymn = by[0]; ymx = by[0];
    for (int i = 0; i < n; i++) begin
      sx += bx[i];
      sy += by[i];
      if (bx[i] < xmn) xmn = bx[i];
      if (bx[i] > xmx) xmx = bx[i];
      if (by[i] < ymn) ymn = by[i];
      if (by[i] > ymx) ymx = by[i];
      if (i > 0) begin
        if (by[i] == by[i-1] + 1) rows++;
        legal = (by[i] == by[i-1] && bx[i] == bx[i-1] + 1) || (by[i] == by[i-1] + 1);
        if (mode == 2'd0 && !legal) oerr = 1'b1;
      end
    end
    if (n > 65535) n = 65535;
    if (rows > 65535) rows = 65535;
    r.mode = mode;
    r.cnt  = n[CNT_W-1:0];
    r.rows = rows[CNT_W-1:0];
    r.xmin = xmn[7:0];
    r.xmax = xmx[7:0];
    r.ymin = ymn[7:0];
    r.ymax = ymx[7:0];
    r.sumx = sx[SUM_W-1:0];
    r.sumy = sy[SUM_W-1:0];
    r.oerr = oerr;
    return r;
  endfunction

  // Drives the beats in bx/by; returns just after the last beat's edge with in_valid low.
  task automatic drive_beats(input logic [1:0] mode);
    int t;
    for (int i = 0; i < bx.size(); i++) begin
      in_valid = 1'b1;
      in_mode  = (i == 0) ? mode : 2'($urandom_range(0, 3));
      t = bx[i]; xi = t[7:0];
      t = by[i]; yi = t[7:0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    xi = 8'($urandom);
    yi = 8'($urandom);
  endtask

  task automatic gen_frame(input logic [1:0] mode, input int len);
    int x, y, r;
    bx.delete(); by.delete();
    x = $urandom_range(0, 80) - 40;
    y = $urandom_range(0, 80) - 40;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        r = $urandom_range(0, 99);
        if (r < 65) begin
          x = x + 1;
        end else if (r < 92) begin
          y = y + 1;
          x = $urandom_range(0, 80) - 40;
        end else begin
          x = $urandom_range(0, 255) - 128;
          y = $urandom_range(0, 80) - 40;
        end
      end
      bx.push_back(x);
      by.push_back(y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'd0; xi = '0; yi = '0; out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_drop !== 1'b0 || dut_rec !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b drop=%b rec=%h, required valid=0 drop=0 rec=0",
               out_valid, out_drop, dut_rec);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    rec_t exp;
    logic [1:0] md;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bx.delete(); by.delete();
      case (k)
        0: begin md = 2'd0; bx = '{0, 1, 2, 0, 1}; by = '{0, 0, 0, 1, 1}; end
        1: begin md = 2'd2; bx = '{1}; by = '{44}; end
        default: begin md = 2'd0; bx = '{-3, -2, 0}; by = '{-1, -1, -1}; end
      endcase
      exp = model_rec(md);
      drive_beats(md);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_latency: out_valid=%b before commit edge, required 0", k, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== exp) begin
        errors++;
        $display("FAIL directed%0d_record: valid=%b rec=%h, required valid=1 rec=%h", k, out_valid, dut_rec, exp);
      end
      $display("directed%0d mode=%0d cnt=%0d rows=%0d oerr=%b", k, out_mode, out_cnt, out_rows, out_oerr);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_accept: out_valid=%b after accept, required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_random_frames();
    rec_t exp;
    logic [1:0] md;
    int gap;
    out_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      md = 2'($urandom_range(0, 2));
      gen_frame(md, $urandom_range(1, 14));
      exp = model_rec(md);
      drive_beats(md);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL random%0d_latency: out_valid=%b before commit edge, required 0", f, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== exp || out_drop !== exp_drop) begin
        errors++;
        $display("FAIL random%0d_record: valid=%b drop=%b rec=%h, required valid=1 drop=%b rec=%h",
                 f, out_valid, out_drop, dut_rec, exp_drop, exp);
      end
      $display("random%0d mode=%0d beats=%0d rows=%0d oerr=%b", f, md, bx.size(), out_rows, out_oerr);
      // gap 0 starts the next frame on the edge right after the frame-end edge
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    rec_t exp_a;
    out_ready = 1'b0;
    bx = '{5, 6, 7}; by = '{-2, -2, -2};
    exp_a = model_rec(2'd1);
    drive_beats(2'd1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || dut_rec !== exp_a || out_drop !== 1'b0) begin
      errors++;
      $display("FAIL overflow_first: valid=%b drop=%b rec=%h, required valid=1 drop=0 rec=%h",
               out_valid, out_drop, dut_rec, exp_a);
    end
    bx = '{-9, 20}; by = '{3, 4};
    drive_beats(2'd0);
    @(posedge clk); #1;
    exp_drop = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || dut_rec !== exp_a || out_drop !== exp_drop) begin
      errors++;
      $display("FAIL overflow_hold: valid=%b drop=%b rec=%h, required valid=1 drop=1 rec=%h",
               out_valid, out_drop, dut_rec, exp_a);
    end
    $display("overflow held cnt=%0d drop=%b", out_cnt, out_drop);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_drop !== exp_drop) begin
      errors++;
      $display("FAIL overflow_release: valid=%b drop=%b, required valid=0 drop=1", out_valid, out_drop);
    end
  endtask

  task automatic test_accept_with_commit();
    rec_t exp_a, exp_b;
    out_ready = 1'b0;
    bx = '{0, 1, 2, 3}; by = '{10, 10, 10, 10};
    exp_a = model_rec(2'd0);
    drive_beats(2'd0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || dut_rec !== exp_a) begin
      errors++;
      $display("FAIL same_edge_first: valid=%b rec=%h, required valid=1 rec=%h", out_valid, dut_rec, exp_a);
    end
    bx = '{127, -128, 127}; by = '{-128, -127, 127};
    exp_b = model_rec(2'd0);
    drive_beats(2'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || dut_rec !== exp_b || out_drop !== exp_drop) begin
      errors++;
      $display("FAIL same_edge_second: valid=%b drop=%b rec=%h, required valid=1 drop=%b rec=%h",
               out_valid, out_drop, dut_rec, exp_drop, exp_b);
    end
    $display("same_edge commit cnt=%0d oerr=%b", out_cnt, out_oerr);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_accept: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    rec_t exp;
    int t;
    out_ready = 1'b1;
    bx = '{30, 31}; by = '{30, 30};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_mode = 2'd0;
      t = bx[i]; xi = t[7:0];
      t = by[i]; yi = t[7:0];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    exp_drop = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_drop !== exp_drop || dut_rec !== '0) begin
      errors++;
      $display("FAIL midframe_reset: valid=%b drop=%b rec=%h, required all zero", out_valid, out_drop, dut_rec);
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bx = '{-5, -4, 2}; by = '{7, 7, 8};
    exp = model_rec(2'd0);
    drive_beats(2'd0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || dut_rec !== exp || out_drop !== exp_drop) begin
      errors++;
      $display("FAIL midframe_after: valid=%b drop=%b rec=%h, required valid=1 drop=0 rec=%h",
               out_valid, out_drop, dut_rec, exp);
    end
    $display("after reset cnt=%0d sumx=%0d", out_cnt, out_sumx);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_frames();
    test_overflow();
    test_accept_with_commit();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
